// File: rtl/fnd_pkg.sv
// fnd_pkg -- shared constants for the four-digit multiplexed 7-segment scanner.
// Holds the active-low glyph table (0-9 plus BLANK), the default scan timing,
// the segment/common active levels and the digit-index enum. There are no ports.
package fnd_pkg;

  // Default timing: clk cycles per digit slot, and dark cycles at slot start.
  localparam int DIV_DEFAULT   = 50000;
  localparam int GUARD_DEFAULT = 2;

  // Both segments and commons are driven active-low.
  localparam logic SEG_ON  = 1'b0;
  localparam logic SEG_OFF = 1'b1;
  localparam logic COM_ON  = 1'b0;
  localparam logic COM_OFF = 1'b1;

  localparam logic [7:0] SEG_ALL_OFF = {8{SEG_OFF}};
  localparam logic [3:0] COM_ALL_OFF = {4{COM_OFF}};

  // Glyphs ordered {g,f,e,d,c,b,a}, 0 = segment lit.
  localparam logic [6:0] GLYPH_0     = 7'b100_0000;
  localparam logic [6:0] GLYPH_1     = 7'b111_1001;
  localparam logic [6:0] GLYPH_2     = 7'b010_0100;
  localparam logic [6:0] GLYPH_3     = 7'b011_0000;
  localparam logic [6:0] GLYPH_4     = 7'b001_1001;
  localparam logic [6:0] GLYPH_5     = 7'b001_0010;
  localparam logic [6:0] GLYPH_6     = 7'b000_0010;
  localparam logic [6:0] GLYPH_7     = 7'b111_1000;
  localparam logic [6:0] GLYPH_8     = 7'b000_0000;
  localparam logic [6:0] GLYPH_9     = 7'b001_0000;
  localparam logic [6:0] GLYPH_BLANK = 7'b111_1111;

  // Digit slot index; DIGIT_A is the leftmost digit and scans first.
  typedef enum logic [1:0] {
    DIGIT_A = 2'd0,
    DIGIT_B = 2'd1,
    DIGIT_C = 2'd2,
    DIGIT_D = 2'd3
  } digit_idx_e;

  // Common mask enabling only the selected digit (bit3 = digit a).
  function automatic logic [3:0] com_select(input digit_idx_e idx);
    logic [3:0] mask;
    mask = COM_ALL_OFF;
    case (idx)
      DIGIT_A: mask[3] = COM_ON;
      DIGIT_B: mask[2] = COM_ON;
      DIGIT_C: mask[1] = COM_ON;
      DIGIT_D: mask[0] = COM_ON;
      default: mask = COM_ALL_OFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/fnd_scan_if.sv
// fnd_scan_if -- bundle between the BCD converter stage / display pins and
// the fnd_scan block.
//   done             conversion-complete level (a rising edge loads a new value)
//   bcd_a..bcd_d     BCD digits, a = leftmost
//   lz_blank         1 = blank a leading zero on digit a
//   seg              {dp,g,f,e,d,c,b,a}, active-low
//   com              digit commons, bit3 = digit a, active-low
// master: the side feeding digits and watching the display pins.
// slave : the scanner itself.
interface fnd_scan_if;
  import fnd_pkg::*;

  logic       done;
  logic [3:0] bcd_a;
  logic [3:0] bcd_b;
  logic [3:0] bcd_c;
  logic [3:0] bcd_d;
  logic       lz_blank;
  logic [7:0] seg;
  logic [3:0] com;

  modport master (
    output done, bcd_a, bcd_b, bcd_c, bcd_d, lz_blank,
    input  seg, com
  );

  modport slave (
    input  done, bcd_a, bcd_b, bcd_c, bcd_d, lz_blank,
    output seg, com
  );

endinterface

// File: rtl/fnd_scan_bcd2seg.sv
// bcd2seg -- combinational BCD to 7-segment decoder.
//   bcd    4-bit digit value
//   glyph  {g,f,e,d,c,b,a}, active-low; values 10-15 decode to blank
module bcd2seg
  import fnd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_BLANK;
    case (bcd)
      4'd0:    glyph = GLYPH_0;
      4'd1:    glyph = GLYPH_1;
      4'd2:    glyph = GLYPH_2;
      4'd3:    glyph = GLYPH_3;
      4'd4:    glyph = GLYPH_4;
      4'd5:    glyph = GLYPH_5;
      4'd6:    glyph = GLYPH_6;
      4'd7:    glyph = GLYPH_7;
      4'd8:    glyph = GLYPH_8;
      4'd9:    glyph = GLYPH_9;
      default: glyph = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/fnd_scan.sv
// fnd_scan -- four-digit multiplexed 7-segment display scanner.
// A rising edge on done loads the four BCD digits into a shadow register; a
// prescaler walks the digits a,b,c,d in DIV-cycle slots, keeping every common
// dark for the first GUARD cycles of each slot to avoid ghosting.
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  fnd_scan_if.slave: done, bcd_a..d, lz_blank in; seg, com out
// seg and com are both registered from the same scan state, so they stay
// aligned to each other with one cycle of latency.
module fnd_scan
  import fnd_pkg::*;
#(
  parameter int DIV   = DIV_DEFAULT,
  parameter int GUARD = GUARD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  fnd_scan_if.slave  bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic          done_q;
  logic          capture;
  logic [15:0]   shadow;
  logic [PW-1:0] presc;
  logic          tick;
  digit_idx_e    idx;
  logic [3:0]    digit_sel;
  logic [3:0]    digit_dec;
  logic          blank_lead;
  logic [6:0]    glyph;
  logic [7:0]    seg_d;
  logic [3:0]    com_d;
  logic [7:0]    seg_q;
  logic [3:0]    com_q;

  // done is a multi-cycle level; only its rising edge loads the shadow.
  // done_q is cleared in reset so a done already high at release still counts.
  assign capture = bus.done & ~done_q;
  assign tick    = (presc == PW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
      shadow <= '0;
    end else begin
      done_q <= bus.done;
      if (capture) begin
        shadow <= {bus.bcd_a, bus.bcd_b, bus.bcd_c, bus.bcd_d};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= DIGIT_A;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        idx <= digit_idx_e'(idx + 2'd1);
      end
    end
  end

  // Leading-zero blanking is folded into the decoder input (an out-of-range
  // code decodes to blank) so a single decoder serves every slot.
  always_comb begin
    digit_sel = shadow[15:12];
    case (idx)
      DIGIT_A: digit_sel = shadow[15:12];
      DIGIT_B: digit_sel = shadow[11:8];
      DIGIT_C: digit_sel = shadow[7:4];
      DIGIT_D: digit_sel = shadow[3:0];
      default: digit_sel = shadow[15:12];
    endcase
    blank_lead = bus.lz_blank && (idx == DIGIT_A) && (shadow[15:12] == 4'd0);
    digit_dec  = blank_lead ? 4'hF : digit_sel;
  end

  bcd2seg u_bcd2seg (
    .bcd   (digit_dec),
    .glyph (glyph)
  );

  // The decimal point separates digit b from digit c.
  always_comb begin
    seg_d = {((idx == DIGIT_B) ? SEG_ON : SEG_OFF), glyph};
    com_d = (presc < PW'(GUARD)) ? COM_ALL_OFF : com_select(idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_ALL_OFF;
      com_q <= COM_ALL_OFF;
    end else begin
      seg_q <= seg_d;
      com_q <= com_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.com = com_q;

endmodule

// File: tb/tb_fnd_scan.sv
// tb_fnd_scan -- directed self-checking bench for fnd_scan with DIV=8, GUARD=2.
// The bench counts clock edges since reset release on its own and derives the
// expected com pattern from that count; the expected seg byte per digit slot is
// a hand-computed table updated whenever the displayed value should change.
module tb_fnd_scan;

  localparam int DIV   = 8;
  localparam int GUARD = 2;

  logic clk;
  logic rst;

  fnd_scan_if bus ();

  fnd_scan #(
    .DIV   (DIV),
    .GUARD (GUARD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks;
  int         fails;
  int         cyc;
  string      phase_name;
  logic [7:0] exp_glyph [4];

  // Every comparison funnels through here so the counters stay consistent.
  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s/%s cyc=%0d observed=%h expected=%h", phase_name, tag, cyc, obs, exp);
    end
  endtask

  // Advance n clock edges; after each, compare seg/com against the model.
  // Outputs after edge k reflect the scan state left by edge k-1.
  task automatic step_check(input int n);
    logic       rst_at_edge;
    logic [7:0] exp_seg;
    logic [3:0] exp_com;
    int         p;
    int         i;
    for (int s = 0; s < n; s++) begin
      rst_at_edge = rst;
      @(posedge clk);
      #1;
      if (rst_at_edge) begin
        cyc     = 0;
        exp_seg = 8'hFF;
        exp_com = 4'hF;
      end else begin
        cyc++;
        p       = (cyc - 1) % DIV;
        i       = ((cyc - 1) / DIV) % 4;
        exp_com = 4'hF;
        if (p >= GUARD) exp_com[3 - i] = 1'b0;
        exp_seg = exp_glyph[i];
      end
      check_output("seg", bus.seg, exp_seg);
      check_output("com", {4'h0, bus.com}, {4'h0, exp_com});
      checks++;
      assert ($countones(~bus.com) <= 1) else begin
        fails++;
        $error("[TB] FAIL %s/com_onehot cyc=%0d observed=%b expected=at most one low", phase_name, cyc, bus.com);
      end
    end
  endtask

  task automatic set_bcd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    bus.bcd_a = a;
    bus.bcd_b = b;
    bus.bcd_c = c;
    bus.bcd_d = d;
  endtask

  task automatic set_exp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    exp_glyph[0] = a;
    exp_glyph[1] = b;
    exp_glyph[2] = c;
    exp_glyph[3] = d;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    cyc    = 0;
    rst    = 1'b1;
    bus.done     = 1'b0;
    bus.lz_blank = 1'b0;
    set_bcd(4'd0, 4'd0, 4'd0, 4'd0);
    set_exp(8'hC0, 8'h40, 8'hC0, 8'hC0);

    // Reset state, then a full scan of the zeroed shadow.
    phase_name = "reset";
    step_check(3);
    rst = 1'b0;
    phase_name = "scan_zero";
    step_check(32);

    // "12.34", with done held high 14 cycles and bcd changed while still high.
    phase_name = "load_1234";
    set_bcd(4'd1, 4'd2, 4'd3, 4'd4);
    bus.done = 1'b1;
    step_check(1);
    set_exp(8'hF9, 8'h24, 8'hB0, 8'h99);
    step_check(4);
    set_bcd(4'd9, 4'd9, 4'd9, 4'd9);
    step_check(9);
    bus.done = 1'b0;
    step_check(32);

    // Leading-zero suppression on " 5.09", then shown again as "05.09".
    phase_name = "lz_blank";
    set_bcd(4'd0, 4'd5, 4'd0, 4'd9);
    bus.lz_blank = 1'b1;
    bus.done     = 1'b1;
    step_check(1);
    set_exp(8'hFF, 8'h12, 8'hC0, 8'h90);
    bus.done = 1'b0;
    step_check(32);
    phase_name = "lz_off";
    bus.lz_blank = 1'b0;
    exp_glyph[0] = 8'hC0;
    step_check(32);

    // Non-decimal code on digit c blanks only that digit.
    phase_name = "code_c";
    set_bcd(4'd1, 4'd2, 4'hC, 4'd4);
    bus.done = 1'b1;
    step_check(1);
    set_exp(8'hF9, 8'h24, 8'hFF, 8'h99);
    bus.done = 1'b0;
    step_check(32);

    // done rising edge coinciding with the prescaler tick.
    phase_name = "tick_capture";
    for (int g = 0; g < DIV && (cyc % DIV) != DIV - 1; g++) step_check(1);
    check_output("tick_align", 8'((cyc % DIV)), 8'(DIV - 1));
    set_bcd(4'd8, 4'd7, 4'd6, 4'd5);
    bus.done = 1'b1;
    step_check(1);
    set_exp(8'h80, 8'h78, 8'h82, 8'h92);
    bus.done = 1'b0;
    step_check(32);

    // One-cycle reset pulse inside the digit-c slot.
    phase_name = "reset_mid";
    for (int g = 0; g < 32 && (cyc % 32) != 20; g++) step_check(1);
    check_output("slot_c_align", 8'((cyc % 32)), 8'd20);
    rst = 1'b1;
    step_check(1);
    rst = 1'b0;
    set_exp(8'hC0, 8'h40, 8'hC0, 8'hC0);
    step_check(32);

    // done already high when reset releases loads on the first free cycle.
    phase_name = "done_at_release";
    rst = 1'b1;
    set_bcd(4'd3, 4'd1, 4'd4, 4'd1);
    bus.done = 1'b1;
    step_check(2);
    rst = 1'b0;
    step_check(1);
    set_exp(8'hB0, 8'h79, 8'h99, 8'hF9);
    step_check(32);
    bus.done = 1'b0;
    step_check(8);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fnd_scan.md
FND_SCAN -- requirements
Module: fnd_scan

Interface
REQ-001 Parameter DIV, default 50000, meaning clk cycles per digit slot (>=4).
REQ-002 Parameter GUARD, default 2, meaning all-digits-off cycles at the start of each slot (<DIV).
REQ-003 Port clk  input  1  system clock, all logic on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port done  input  1  conversion-complete level from the BCD converter stage, high for several consecutive cycles per result.
REQ-006 Port bcd_a, bcd_b, bcd_c, bcd_d  input  4 each  BCD digits, a = leftmost, d = rightmost.
REQ-007 Port lz_blank  input  1  1 = suppress leading zero on digit a.
REQ-008 Port seg  output  8  segment drive {dp,g,f,e,d,c,b,a}, active-low.
REQ-009 Port com  output  4  digit-common drive, bit3 = digit a … bit0 = digit d, active-low.

Function
REQ-010 done is registered once; capture event = done high while its registered copy is low (rising edge).
REQ-011 On a capture event, the block shall load bcd_a..bcd_d into a 16-bit shadow register in that same clock edge.
REQ-012 The shadow register shall change only on capture events; a held-high done shall cause exactly one load.
REQ-013 Prescaler: counter 0..DIV-1, wraps to 0; tick asserted when counter = DIV-1.
REQ-014 Digit index: 2-bit, advances 0->1->2->3->0 on each tick, index 0 selects digit a.
REQ-015 Slot phase = prescaler value; for phase < GUARD, com shall be 4'b1111 (ghost guard).
REQ-016 For phase >= GUARD, com shall drive low exactly the bit of the current index, others high.
REQ-017 seg shall be the decoded pattern of the shadow digit selected by the index, 1-cycle registered latency relative to index/shadow.
REQ-018 Decode: values 0–9 produce standard 7-segment glyphs; values 10–15 produce blank (g..a all 1).
REQ-019 Leading-zero rule: when lz_blank=1 and shadow digit a = 0, digit a slot shall output blank g..a.
REQ-020 dp (seg[7]) shall be 0 (lit) only while index = 1 (separator after digit b), else 1.
REQ-021 Capture event and tick in the same cycle: both take effect; next displayed digit uses the new shadow.
REQ-022 Digit change in the middle of a slot (capture event): seg shall reflect the new value from the next cycle; com unaffected.
REQ-023 Outputs shall be glitch-free registers; no combinational path from inputs to seg/com.

Reset
REQ-024 While rst=1: shadow = 0, done register = 0, prescaler = 0, index = 0, seg = 8'hFF, com = 4'hF.
REQ-025 Reset asserted mid-slot shall blank the display in the next cycle; after release, scanning restarts at digit a, phase 0.
REQ-026 A done already high when rst deasserts shall count as a capture event on the first cycle after release.

Structure
REQ-027 Shared package fnd_pkg shall hold the 7-segment glyph constants (0–9, BLANK), DIV/GUARD defaults, and the segment/common active-level constants.
REQ-028 One sub-module, bcd2seg (4-bit BCD in, 7-bit active-low glyph out, combinational), shall be instantiated once on the muxed digit.
REQ-029 Prescaler, index, shadow and output registers reside in fnd_scan; target size 120–250 lines.

Verification (DIV=8, GUARD=2)
REQ-030 Reset then release, no done -> com cycles 0111,1011,1101,1110 each for 6 cycles after 2 cycles of 1111; seg = glyph "0" with dp on digit b only.
REQ-031 bcd = 1,2,3,4, done high 14 cycles -> one shadow load; display reads "12.34"; changing bcd inputs while done stays high has no effect.
REQ-032 lz_blank=1, bcd = 0,5,0,9 -> digit a seg = 8'hFF, display " 5.09"; lz_blank=0 -> "05.09".
REQ-033 bcd_c = 4'hC -> digit c slot seg[6:0] = 7'h7F, other digits normal.
REQ-034 done rising edge on the same cycle as a tick -> next slot shows the new value; no cycle shows two commons low.
REQ-035 rst pulsed for 1 cycle during the digit-c slot -> seg=FF, com=F next cycle; scan resumes at digit a, shadow = 0.
